frame_serializer_tx: RTL and testbench

//  Serial transmitter for the 10-bit framed byte link used by the RAM memory project.
//  It accepts parallel bytes over a valid/ready handshake, buffers one byte, and emits frames.

---
 rtl/frame_pkg.sv | 20 ++
 rtl/frame_hold_reg.sv | 32 +++
 rtl/frame_serializer_tx.sv | 134 +++++++++++++
 tb/tb_frame_serializer_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types and line levels for the framed byte serial link.
package frame_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Default link format: 8 data bits, 1 stop bit.
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_STOP_BITS = 1;
  localparam int FRAME_LEN     = 1 + DEF_DATA_BITS + DEF_STOP_BITS;

  // Strobes per frame for an arbitrary format.
  function automatic int frame_len(input int data_bits, input int stop_bits);
    return 1 + data_bits + stop_bits;
  endfunction

endpackage

// File: rtl/frame_hold_reg.sv
// Single-entry valid/ready holding buffer. ready is kept in its own flop
// so the upstream handshake sees a registered signal.
module frame_hold_reg #(
  parameter int W = 8
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [W-1:0] load_data,
  input  logic         load,
  input  logic         drain,
  output logic [W-1:0] data,
  output logic         full,
  output logic         ready
);

  // Load wins only when empty (load implies ready); drain empties the entry.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      data  <= '0;
      full  <= 1'b0;
      ready <= 1'b1;
    end else if (load) begin
      data  <= load_data;
      full  <= 1'b1;
      ready <= 1'b0;
    end else if (drain) begin
      full  <= 1'b0;
      ready <= 1'b1;
    end
  end

endmodule

// File: rtl/frame_serializer_tx.sv
// Framed serial transmitter: start bit, DATA_BITS data bits LSB first,
// STOP_BITS stop bits. The line advances one bit per enable strobe.
module frame_serializer_tx
  import frame_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 outBit,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int SW = $clog2(STOP_BITS + 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_LAST = SW'(STOP_BITS);

  state_t               state_q, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [BW-1:0]        bitcnt_q, bitcnt_n;
  logic [SW-1:0]        stopcnt_q, stopcnt_n;
  logic                 out_q, out_n;
  logic                 done_q, done_n;

  logic                 hold_full;
  logic                 drain;
  logic [DATA_BITS-1:0] hold_data;

  frame_hold_reg #(.W(DATA_BITS)) u_hold (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .load_data (data_in),
    .load      (data_valid && data_ready),
    .drain     (drain),
    .data      (hold_data),
    .full      (hold_full),
    .ready     (data_ready)
  );

  // State register; reset truncates any frame and returns the line to idle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= '0;
      out_q     <= LINE_IDLE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      bitcnt_q  <= bitcnt_n;
      stopcnt_q <= stopcnt_n;
      out_q     <= out_n;
      done_q    <= done_n;
    end
  end

  // Next-state logic: everything holds unless enable strobes; frame_done
  // is a single-clock pulse so it falls back to 0 on any non-ending clock.
  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    bitcnt_n  = bitcnt_q;
    stopcnt_n = stopcnt_q;
    out_n     = out_q;
    done_n    = 1'b0;
    drain     = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (hold_full) begin
            shift_n = hold_data;
            drain   = 1'b1;
            out_n   = START_LEVEL;
            state_n = START;
          end
        end
        START: begin
          out_n    = shift_q[0];
          shift_n  = shift_q >> 1;
          bitcnt_n = B_ONE;
          state_n  = DATA;
        end
        DATA: begin
          if (bitcnt_q < B_LAST) begin
            out_n    = shift_q[0];
            shift_n  = shift_q >> 1;
            bitcnt_n = bitcnt_q + B_ONE;
          end else begin
            out_n     = STOP_LEVEL;
            stopcnt_n = S_ONE;
            state_n   = STOP;
          end
        end
        STOP: begin
          if (stopcnt_q < S_LAST) begin
            stopcnt_n = stopcnt_q + S_ONE;
          end else begin
            done_n = 1'b1;
            if (hold_full) begin
              // Back-to-back: next start bit replaces the idle gap.
              shift_n = hold_data;
              drain   = 1'b1;
              out_n   = START_LEVEL;
              state_n = START;
            end else begin
              out_n   = LINE_IDLE;
              state_n = IDLE;
            end
          end
        end
        default: begin
          out_n   = LINE_IDLE;
          state_n = IDLE;
        end
      endcase
    end
  end

  assign outBit     = out_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_frame_serializer_tx.sv
// Bench for frame_serializer_tx: directed line checks plus a receiver model
// that rebuilds bytes from strobed outBit samples against a scoreboard.
module tb_frame_serializer_tx;

  logic       CLOCK_50 = 1'b0;
  logic       reset, enable, data_valid;
  logic [7:0] data_in;
  logic       data_ready, outBit, busy, frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  int         rx_st = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = '0;
  int         rx_frames = 0;
  bit         last_acc = 0;

  frame_serializer_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .outBit     (outBit),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Expected line sequence for one frame, index 0 = start bit.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Receiver model: start=0, 8 data LSB first, stop=1, then scoreboard pop.
  task automatic rx_sample(input logic b);
    logic [7:0] exp;
    case (rx_st)
      0: if (b === 1'b0) begin rx_st = 1; rx_cnt = 0; rx_byte = '0; end
      1: begin
        rx_byte[rx_cnt] = b;
        rx_cnt++;
        if (rx_cnt == 8) rx_st = 2;
      end
      default: begin
        checks++;
        if (b !== 1'b1) begin errors++; $display("FAIL rx_stop got %b want 1", b); end
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rx_unexpected got %h want none", rx_byte);
        end else begin
          exp = q.pop_front();
          if (rx_byte !== exp) begin errors++; $display("FAIL rx_byte got %h want %h", rx_byte, exp); end
        end
        rx_frames++;
        rx_st = 0;
      end
    endcase
  endtask

  // One clock: note pre-edge handshake/strobe, then observe #1 after the edge.
  task automatic step();
    bit pre_acc, pre_en, pre_rst;
    pre_acc = data_valid && data_ready && !reset;
    pre_en  = enable;
    pre_rst = reset;
    @(posedge CLOCK_50); #1;
    last_acc = pre_acc;
    if (pre_rst) begin
      q.delete(); rx_st = 0;
    end else begin
      if (pre_acc) q.push_back(data_in);
      if (pre_en) rx_sample(outBit);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin step(); n++; end
    checks++;
    if (n >= budget) begin errors++; $display("FAIL %s_timeout got %0d cycles want <%0d", name, n, budget); end
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; data_valid = 0; data_in = '0;
    step(); step();
    checks++; if (outBit !== 1'b1)     begin errors++; $display("FAIL rst_out got %b want 1", outBit); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", data_ready); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", frame_done); end
    reset = 0;
    step();
  endtask

  task automatic test_single();
    logic [9:0] exp = frame_bits(8'hA5);
    int f0 = rx_frames;
    enable = 1; data_in = 8'hA5; data_valid = 1;
    step(); data_valid = 0;
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL a5_ready_full got %b want 0", data_ready); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (outBit !== exp[i] || busy !== 1'b1 || frame_done !== 1'b0) begin
        errors++; $display("FAIL a5_bit%0d got out=%b busy=%b done=%b want out=%b busy=1 done=0", i, outBit, busy, frame_done, exp[i]);
      end
      if (i == 0) begin
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL a5_ready_drain got %b want 1", data_ready); end
      end
    end
    step();
    checks++;
    if (frame_done !== 1'b1 || outBit !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL a5_end got done=%b out=%b busy=%b want 1 1 0", frame_done, outBit, busy);
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || outBit !== 1'b1) begin
      errors++; $display("FAIL a5_idle got done=%b out=%b want 0 1", frame_done, outBit);
    end
    checks++; if (rx_frames - f0 !== 1) begin errors++; $display("FAIL a5_frames got %0d want 1", rx_frames - f0); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp = {frame_bits(8'hFF), frame_bits(8'h00)};
    logic [19:0] got;
    int dones = 0;
    bit gap = 0;
    enable = 1; data_in = 8'h00; data_valid = 1;
    step();
    data_in = 8'hFF;
    for (int i = 0; i < 22; i++) begin
      step();
      if (last_acc) data_valid = 0;
      if (i < 20) begin got[i] = outBit; if (!busy) gap = 1; end
      if (frame_done) dones++;
    end
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_line got %b want %b", got, exp); end
    checks++; if (gap)         begin errors++; $display("FAIL b2b_gap got busy drop want none"); end
    checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done got %0d want 2", dones); end
  endtask

  task automatic test_slow_enable();
    logic [9:0] exp = frame_bits(8'h3C);
    int bad = 0;
    data_in = 8'h3C; data_valid = 1;
    for (int i = 0; i <= 44; i++) begin
      enable = (i % 4 == 0);
      step();
      if (last_acc) data_valid = 0;
      if (i >= 4 && i <= 43 && outBit !== exp[(i-4)/4]) begin
        bad++; $display("FAIL slow_bit clk%0d got %b want %b", i, outBit, exp[(i-4)/4]);
      end
      if (i == 43) begin
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL slow_early_done got 1 want 0"); end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL slow_line got %0d bad clocks want 0", bad); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL slow_done got %b want 1", frame_done); end
    enable = 1;
    step();
  endtask

  task automatic test_stream();
    logic [7:0] b[3] = '{8'h11, 8'h22, 8'h33};
    int idx = 0, n = 0, f0 = rx_frames;
    enable = 1; data_in = b[0]; data_valid = 1;
    while ((idx < 3 || q.size() != 0 || busy) && n < 400) begin
      step(); n++;
      if (last_acc) begin
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL stream_ready got %b want 0", data_ready); end
        idx++;
        if (idx < 3) data_in = b[idx]; else data_valid = 0;
      end
    end
    data_valid = 0;
    checks++; if (n >= 400) begin errors++; $display("FAIL stream_timeout got %0d want <400", n); end
    checks++; if (rx_frames - f0 !== 3) begin errors++; $display("FAIL stream_frames got %0d want 3", rx_frames - f0); end
  endtask

  task automatic test_reset_mid();
    int f0;
    enable = 1; data_in = 8'hC3; data_valid = 1;
    step(); data_valid = 0;
    for (int i = 0; i < 5; i++) step();
    reset = 1;
    step();
    checks++;
    if (outBit !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got out=%b busy=%b ready=%b done=%b want 1 0 1 0", outBit, busy, data_ready, frame_done);
    end
    reset = 0;
    step();
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after got done=%b busy=%b want 0 0", frame_done, busy); end
    f0 = rx_frames;
    data_in = 8'h5A; data_valid = 1;
    step(); data_valid = 0;
    wait_idle(40, "mid_5a");
    checks++; if (rx_frames - f0 !== 1) begin errors++; $display("FAIL mid_frames got %0d want 1", rx_frames - f0); end
  endtask

  task automatic test_random();
    int f0 = rx_frames;
    for (int k = 0; k < 256; k++) begin
      int n = 0;
      data_in = 8'($urandom); data_valid = 1;
      last_acc = 0;
      while (!last_acc && n < 100) begin
        enable = ($urandom_range(0, 3) != 0);
        step(); n++;
      end
      data_valid = 0;
      if (!last_acc) begin
        checks++; errors++; $display("FAIL rand_accept got timeout want accept byte %0d", k);
      end
      if ($urandom_range(0, 3) == 0) begin enable = 1; step(); end
    end
    enable = 1;
    wait_idle(200, "rand");
    checks++; if (rx_frames - f0 !== 256) begin errors++; $display("FAIL rand_frames got %0d want 256", rx_frames - f0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_slow_enable();
    test_stream();
    test_reset_mid();
    test_random();
    checks++; if (q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
